// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter between the MEM stage and the burst loader.
package dmem_arbiter_pkg;

    localparam int unsigned ADR_WIDTH  = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {BIdle, BRun, BDone} b_state_t;

    // A burst is only legal with a non-zero length and a word-aligned start address.
    function automatic logic burst_req_ok(logic len_nonzero, logic [1:0] addr_lsb);
        return len_nonzero && (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating wait counter: counts denied cycles of a pending loader beat up to Limit.
module dmem_starve_cnt #(
    parameter int unsigned Limit = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam int unsigned CntWidth = $clog2(Limit + 1);

    logic [CntWidth-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntWidth'(Limit))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == CntWidth'(Limit));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline port A has combinational priority, loader port B
// runs word bursts and is forced through after STARVE_LIMIT denied cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LEN_WIDTH    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [ADR_WIDTH-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_stall,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADR_WIDTH-1:0]  b_addr,
    input  logic [LEN_WIDTH-1:0]  b_len,
    output logic                  b_ack,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_wnext,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic                  b_done,
    output logic                  b_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    b_state_t              state_q;
    logic [ADR_WIDTH-1:0]  cur_addr_q;
    logic [LEN_WIDTH-1:0]  remain_q;
    logic                  dir_q;
    logic                  b_ack_q, b_err_q, b_done_q, b_rvalid_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;

    logic a_active, grant_b, wait_clr, wait_inc, at_limit;

    dmem_starve_cnt #(
        .Limit(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clr_i     (wait_clr),
        .inc_i     (wait_inc),
        .at_limit_o(at_limit)
    );

    // Everything towards memory is gated by reset so an interrupted beat never half-writes.
    always_comb begin
        a_active  = a_read | a_write;
        grant_b   = rst_n && (state_q == BRun) && (!a_active || at_limit);
        a_stall   = a_active & grant_b;
        wait_clr  = grant_b || (state_q != BRun) || !rst_n;
        wait_inc  = a_active && !grant_b;
        b_wnext   = grant_b & dir_q;
        if (grant_b) begin
            mem_read  = !dir_q;
            mem_write = dir_q;
            mem_addr  = cur_addr_q;
            mem_wdata = b_wdata;
        end else begin
            mem_read  = rst_n & a_read & ~a_write;
            mem_write = rst_n & a_write;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BIdle;
            cur_addr_q <= '0;
            remain_q   <= '0;
            dir_q      <= 1'b0;
            b_ack_q    <= 1'b0;
            b_err_q    <= 1'b0;
            b_done_q   <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            b_ack_q    <= 1'b0;
            b_err_q    <= 1'b0;
            b_done_q   <= 1'b0;
            b_rvalid_q <= 1'b0;
            case (state_q)
                BIdle: begin
                    // The requester drops b_req only once it sees b_ack, so skip that cycle.
                    if (b_req && !b_ack_q) begin
                        b_ack_q <= 1'b1;
                        if (burst_req_ok(b_len != '0, b_addr[1:0])) begin
                            cur_addr_q <= b_addr;
                            remain_q   <= b_len;
                            dir_q      <= b_we;
                            state_q    <= BRun;
                        end else begin
                            b_err_q <= 1'b1;
                        end
                    end
                end
                BRun: begin
                    if (grant_b) begin
                        cur_addr_q <= cur_addr_q + ADR_WIDTH'(WORD_BYTES);
                        remain_q   <= remain_q - 1'b1;
                        if (!dir_q) begin
                            b_rdata_q  <= mem_rdata;
                            b_rvalid_q <= 1'b1;
                        end
                        if (remain_q == LEN_WIDTH'(1)) begin
                            b_done_q <= 1'b1;
                            state_q  <= BDone;
                        end
                    end
                end
                BDone:   state_q <= BIdle;
                default: state_q <= BIdle;
            endcase
        end
    end

    assign a_rdata  = mem_rdata;
    assign b_ack    = b_ack_q;
    assign b_err    = b_err_q;
    assign b_done   = b_done_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a small memory, a per-cycle reference model of the arbitration
// rules and directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_read, a_write;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_stall;
    logic        b_req, b_we;
    logic [31:0] b_addr;
    logic [5:0]  b_len;
    logic        b_ack, b_wnext, b_rvalid, b_done, b_err;
    logic [31:0] b_wdata, b_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .LEN_WIDTH   (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_read   (a_read),
        .a_write  (a_write),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_rdata  (a_rdata),
        .a_stall  (a_stall),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_len    (b_len),
        .b_ack    (b_ack),
        .b_wdata  (b_wdata),
        .b_wnext  (b_wnext),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
        .b_done   (b_done),
        .b_err    (b_err),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // 64-word memory; address bits [7:2] select the word, so 0xFFFFFFFC aliases to word 63.
    logic [31:0] ram [64];
    logic        clr_ram;
    always @(posedge clk) begin
        if (clr_ram) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
        end else if (mem_write) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = ram[mem_addr[7:2]];

    // Write-beat source: data advances by one each time a beat is consumed.
    int          wn_cnt = 0;
    int          wbase;
    logic [31:0] wpat;
    always @(posedge clk) if (b_wnext) wn_cnt <= wn_cnt + 1;
    assign b_wdata = wpat + 32'(wn_cnt - wbase);

    int checks = 0;
    int failures = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Reference model state: phase 0 idle, 1 bursting, 2 finishing.
    int          m_phase = 0, m_left = 0, m_wait = 0;
    logic [31:0] m_addr = '0, m_rdata = '0;
    logic        m_dir = 1'b0, m_ack = 1'b0, m_err = 1'b0, m_done = 1'b0, m_rvalid = 1'b0;
    logic        chk_en = 1'b0;
    int          cnt_stall = 0, cnt_rvalid = 0, cnt_done = 0, cnt_err = 0, cnt_wnext = 0;
    logic [31:0] last_rdata = '0;

    always @(negedge clk) begin
        logic a_act, grant, bad, prev_ack;
        a_act = a_read | a_write;
        grant = rst_n && (m_phase == 1) && (!a_act || (m_wait == LIMIT));
        bad   = (b_len == 6'd0) || (b_addr[1:0] != 2'b00);
        if (chk_en) begin
            chk1("a_stall", a_stall, a_act && grant);
            chk1("b_wnext", b_wnext, grant && m_dir);
            if (grant) begin
                chk32("mem_addr_b", mem_addr, m_addr);
                chk1("mem_write_b", mem_write, m_dir);
                chk1("mem_read_b", mem_read, !m_dir);
                if (m_dir) chk32("mem_wdata_b", mem_wdata, b_wdata);
            end else begin
                chk1("mem_read_a", mem_read, rst_n && a_read && !a_write);
                chk1("mem_write_a", mem_write, rst_n && a_write);
                if (a_act) chk32("mem_addr_a", mem_addr, a_addr);
                if (rst_n && a_read && !a_write) chk32("a_rdata", a_rdata, ram[a_addr[7:2]]);
            end
            chk1("b_ack", b_ack, m_ack);
            chk1("b_err", b_err, m_err);
            chk1("b_done", b_done, m_done);
            chk1("b_rvalid", b_rvalid, m_rvalid);
            if (m_rvalid) chk32("b_rdata", b_rdata, m_rdata);
            if (a_stall) cnt_stall++;
            if (b_rvalid) begin cnt_rvalid++; last_rdata = b_rdata; end
            if (b_done) cnt_done++;
            if (b_err) cnt_err++;
            if (b_wnext) cnt_wnext++;
        end
        // Advance the model to what the next clock edge must produce.
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_wait = 0;
            m_ack = 0; m_err = 0; m_done = 0; m_rvalid = 0; m_rdata = '0;
        end else begin
            prev_ack = m_ack;
            m_ack = 0; m_err = 0; m_done = 0; m_rvalid = 0;
            case (m_phase)
                0: if (b_req && !prev_ack) begin
                    m_ack = 1;
                    if (bad) m_err = 1;
                    else begin
                        m_phase = 1; m_addr = b_addr; m_left = int'(b_len); m_dir = b_we;
                    end
                end
                1: if (grant) begin
                    if (!m_dir) begin m_rvalid = 1; m_rdata = ram[m_addr[7:2]]; end
                    m_addr = m_addr + 32'd4;
                    m_left = m_left - 1;
                    m_wait = 0;
                    if (m_left == 0) begin m_phase = 2; m_done = 1; end
                end else if (a_act) begin
                    m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
                end
                default: m_phase = 0;
            endcase
            if (m_phase != 1) m_wait = 0;
        end
    end

    task automatic run_burst(input logic we, input logic [31:0] addr, input logic [5:0] len);
        logic ok;
        ok = 1'b0;
        b_we = we; b_addr = addr; b_len = len; b_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (b_ack) begin ok = 1'b1; break; end
        end
        b_req = 1'b0;
        chk1("ack_seen", ok, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int s_stall, s_rvalid, s_done, s_err, s_wnext;
        rst_n = 0; a_read = 0; a_write = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_len = '0;
        wpat = '0; wbase = 0; clr_ram = 1;
        @(posedge clk); #1;
        chk_en = 1;
        a_read = 1; a_addr = 32'h10;
        @(negedge clk);
        chk1("rst_a_stall", a_stall, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk32("rst_b_rdata", b_rdata, 32'h0);
        chk1("rst_b_ack", b_ack, 1'b0);
        @(posedge clk); #1;
        a_read = 0; clr_ram = 0; rst_n = 1;

        // Port A alone: store then load the same word
        a_write = 1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        a_write = 0; a_read = 1;
        @(negedge clk);
        chk32("a_load_same_cycle", a_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        a_read = 0;
        chk32("a_alone_stalls", 32'(cnt_stall), 32'd0);

        // Write burst with A idle
        s_done = cnt_done; s_wnext = cnt_wnext;
        wpat = 32'd1; wbase = wn_cnt;
        run_burst(1'b1, 32'h20, 6'd3);
        idle(6);
        chk32("wr_word0", ram[8], 32'd1);
        chk32("wr_word1", ram[9], 32'd2);
        chk32("wr_word2", ram[10], 32'd3);
        chk32("wr_wnext_cnt", 32'(cnt_wnext - s_wnext), 32'd3);
        chk32("wr_done_cnt", 32'(cnt_done - s_done), 32'd1);

        // Read burst with A loading every cycle: one forced stall per five cycles
        s_stall = cnt_stall; s_rvalid = cnt_rvalid; s_done = cnt_done;
        a_read = 1; a_addr = 32'h10;
        run_burst(1'b0, 32'h20, 6'd3);
        idle(20);
        a_read = 0;
        idle(3);
        chk32("rd_stall_cnt", 32'(cnt_stall - s_stall), 32'd3);
        chk32("rd_rvalid_cnt", 32'(cnt_rvalid - s_rvalid), 32'd3);
        chk32("rd_done_cnt", 32'(cnt_done - s_done), 32'd1);
        chk32("rd_last_data", last_rdata, 32'd3);

        // Rejected requests
        s_err = cnt_err; s_done = cnt_done; s_wnext = cnt_wnext;
        run_burst(1'b0, 32'h30, 6'd0);
        idle(2);
        run_burst(1'b1, 32'h22, 6'd2);
        idle(4);
        chk32("err_cnt", 32'(cnt_err - s_err), 32'd2);
        chk32("err_no_done", 32'(cnt_done - s_done), 32'd0);
        chk32("err_no_wnext", 32'(cnt_wnext - s_wnext), 32'd0);

        // Reset after the first beat of a 4-beat write
        s_done = cnt_done;
        wpat = 32'hA0; wbase = wn_cnt;
        run_burst(1'b1, 32'h40, 6'd4);
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        idle(6);
        chk32("rst_word0", ram[16], 32'hA0);
        chk32("rst_word1", ram[17], 32'h0);
        chk32("rst_no_done", 32'(cnt_done - s_done), 32'd0);
        wpat = 32'h77; wbase = wn_cnt;
        run_burst(1'b1, 32'h40, 6'd2);
        idle(5);
        chk32("post_rst_word0", ram[16], 32'h77);
        chk32("post_rst_word1", ram[17], 32'h78);
        chk32("post_rst_done", 32'(cnt_done - s_done), 32'd1);

        // Address wrap across the top of the address space
        s_done = cnt_done;
        wpat = 32'h55; wbase = wn_cnt;
        run_burst(1'b1, 32'hFFFFFFFC, 6'd2);
        idle(5);
        chk32("wrap_word_top", ram[63], 32'h55);
        chk32("wrap_word_zero", ram[0], 32'h56);
        chk32("wrap_done", 32'(cnt_done - s_done), 32'd1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline MEM stage (port A, latency-critical) and a loader/debug burst engine (port B). Port A has default priority and sees the memory combinationally, exactly as if it were wired straight to the memory. Port B issues word bursts through an req/ack handshake and receives registered read data. A starvation counter forces B slots by stalling the pipeline. Sits between the MEM stage, memory_data, and the loader.

Parameters:
STARVE_LIMIT, 4, consecutive denied cycles after which a pending B beat is forced through (1..15)
LEN_WIDTH, 6, width of the B burst length field (bursts of 1..2^LEN_WIDTH-1 words)

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  synchronous active-low reset
a_read  input  1  pipeline load request (MemRead of MEM stage)
a_write  input  1  pipeline store request (MemWrite of MEM stage)
a_addr  input  `ADR_WIDTH  pipeline byte address
a_wdata  input  `DATA_WIDTH  pipeline store data
a_rdata  output  `DATA_WIDTH  pipeline load data, combinational from memory
a_stall  output  1  pipeline must hold the MEM stage this cycle
b_req  input  1  start burst; held high until b_ack
b_we  input  1  burst direction: 1 write, 0 read; sampled with b_req
b_addr  input  `ADR_WIDTH  burst start byte address, word aligned
b_len  input  LEN_WIDTH  burst word count; 0 is illegal
b_ack  output  1  one-cycle pulse: burst accepted
b_wdata  input  `DATA_WIDTH  write data for the current beat
b_wnext  output  1  current write beat consumed; source advances b_wdata
b_rdata  output  `DATA_WIDTH  registered read beat data
b_rvalid  output  1  b_rdata valid, one cycle per beat
b_done  output  1  one-cycle pulse after the last beat
b_err  output  1  one-cycle pulse: request rejected (b_len==0 or b_addr[1:0]!=0)
mem_read  output  1  to memory MemRead
mem_write  output  1  to memory MemWrite
mem_addr  output  `ADR_WIDTH  to memory addr
mem_wdata  output  `DATA_WIDTH  to memory data_write
mem_rdata  input  `DATA_WIDTH  from memory data_read (combinational)

Behaviour:
- Reset (rst_n low at posedge): FSM to B_IDLE, wait_cnt=0, beat counter=0, b_ack=b_done=b_err=b_rvalid=0, b_rdata=0. During reset, mem_read=mem_write=0 and a_stall=0.
- FSM states:
  - B_IDLE: accepts a burst when b_req=1. Valid request: load cur_addr=b_addr, remain=b_len, dir=b_we, pulse b_ack, go to B_RUN. Invalid request: pulse b_err and b_ack, stay in B_IDLE.
  - B_RUN: one beat per granted cycle. The beat that takes remain to 0 goes to B_DONE.
  - B_DONE: pulse b_done for one cycle, return to B_IDLE. A new b_req is accepted on the following cycle, never in B_DONE.
- a_active = a_read | a_write. a_read and a_write both high is illegal; treat it as a write.
- Grant rule in B_RUN: grant_b = !a_active | (wait_cnt == STARVE_LIMIT). In all other states grant_b = 0.
- a_stall = a_active & grant_b. When stalled, A's request is not presented to memory.
- Memory mux:
  - grant_b=1: mem_* driven from cur_addr / dir / b_wdata.
  - grant_b=0: mem_* driven from a_*.
  - a_rdata = mem_rdata always; it is valid only when A is granted.
- wait_cnt, in B_RUN only:
  - Increments (saturating at STARVE_LIMIT) on cycles with a_active and no grant.
  - Clears to 0 on every B grant and outside B_RUN.
- A stalled cycle is always followed by an A-eligible cycle, because wait_cnt is 0 after the forced grant. No back-to-back forced stalls unless A is idle.
- On a B grant: cur_addr += 4 and remain -= 1. cur_addr wraps modulo 2^`ADR_WIDTH without error.
- B write beat: b_wnext pulses in the grant cycle.
- B read beat: b_rdata <= mem_rdata on that posedge; b_rvalid=1 in the next cycle. Latency from grant to data is 1 cycle.
- b_done asserts in the same cycle as the last b_rvalid.
- b_req is ignored while the FSM is outside B_IDLE.
- Reset mid-burst: burst is abandoned with no b_done; the interrupted beat's write is either complete or never issued, never partial.

Decomposition:
- Shared package / define.sv: `ADR_WIDTH, `DATA_WIDTH; enum b_state_t {B_IDLE, B_RUN, B_DONE}; localparam WORD_BYTES=4.
- One natural sub-module: dmem_starve_cnt, a saturating counter with clear/inc/at_limit.

Test Plan:
- A alone: a_write addr=0x10 data=0xDEADBEEF, then a_read 0x10 → a_rdata=0xDEADBEEF same cycle, a_stall never 1.
- B write burst, A idle: b_addr=0x20, b_len=3, data 1,2,3 → b_ack at cycle 1, three consecutive b_wnext, b_done after third; mem 0x20/0x24/0x28 = 1/2/3.
- B read burst, A read every cycle, STARVE_LIMIT=4 → exactly one a_stall per 5 cycles; each b_rvalid 1 cycle after its forced grant; b_done after 3rd beat.
- Errors: b_len=0 → b_err+b_ack pulse, no memory access; b_addr=0x22 → b_err, FSM stays B_IDLE.
- Reset asserted after beat 1 of a 4-beat write → no b_done, FSM B_IDLE, only word 0 written; a new burst after reset completes normally.
- Address wrap: b_addr=0xFFFFFFFC, b_len=2 → beats at 0xFFFFFFFC then 0x00000000, b_done asserted.
